// File: rtl/csi_pkt_gate.sv
// ---------------------------------------------------------------------------
// csi_pkt_gate
//
// Finds CSI-2 packets on a 1/2/4-lane PHY byte stream and gates them.
//
// A start-of-transmission (SoT) beat has every lane byte equal to 8'hB8. The
// packet header follows it: DI, WC_lo, WC_hi, ECC. These bytes are spread
// round-robin across the lanes, lane 0 first. A short packet (DI[5:0] < 0x10)
// ends after its header. A long packet carries WC payload bytes followed by
// CRC_BYTES trailer bytes. The whole packet is gated, one beat per byte group.
// out_data is the input stream delayed by one clock. out_gate is aligned
// with out_data and marks the beats that belong to a packet.
//
// Parameters
//   LANES      active data lanes (1, 2 or 4)
//   MAX_WC     largest accepted long-packet word count, in bytes
//   CRC_BYTES  trailer bytes that follow a long-packet payload
//
// Ports
//   clk        PHY byte clock; all logic runs on its rising edge
//   reset      synchronous, active-high
//   lane_valid PHY ready; lane_data is meaningful only while high
//   lane_data  lane bytes, lane 0 in bits [7:0]
//   out_data   lane_data delayed by one clock
//   out_gate   high on beats belonging to a packet, aligned with out_data
//   hdr_valid  one-cycle pulse when a complete header has been captured
//   hdr_di     captured data identifier
//   hdr_wc     captured word count
//   hdr_ecc    captured header ECC byte (not checked)
//   len_err    one-cycle pulse when a long packet's WC exceeds MAX_WC
//   abort      one-cycle pulse when lane_valid drops inside a packet
//   pkt_count  completed packets, wraps modulo 2^16
// ---------------------------------------------------------------------------
module csi_pkt_gate #(
    parameter int unsigned LANES     = 4,
    parameter logic [15:0] MAX_WC    = 16'd8192,
    parameter int unsigned CRC_BYTES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lane_valid,
    input  logic [8*LANES-1:0] lane_data,
    output logic [8*LANES-1:0] out_data,
    output logic               out_gate,
    output logic               hdr_valid,
    output logic [7:0]         hdr_di,
    output logic [15:0]        hdr_wc,
    output logic [7:0]         hdr_ecc,
    output logic               len_err,
    output logic               abort,
    output logic [15:0]        pkt_count
);

    // The header is 4 bytes, so it takes 4/LANES beats.
    localparam int unsigned HDR_BEATS = 4 / LANES;
    localparam logic [1:0]  HDR_LAST  = 2'(HDR_BEATS - 1);
    localparam logic [7:0]  SOT_BYTE  = 8'hB8;

    // 17-bit operands: WC + trailer + rounding can exceed 16 bits.
    localparam logic [16:0] CRC_EXT   = 17'(CRC_BYTES);
    localparam logic [16:0] ROUND_UP  = 17'(LANES - 1);
    localparam logic [16:0] LANES_EXT = 17'(LANES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [1:0]          hdr_idx_q,   hdr_idx_d;
    logic [16:0]         beat_cnt_q,  beat_cnt_d;
    logic [8*LANES-1:0]  out_data_q;
    logic                out_gate_q,  out_gate_d;
    logic                hdr_valid_q, hdr_valid_d;
    logic [7:0]          hdr_di_q,    hdr_di_d;
    logic [15:0]         hdr_wc_q,    hdr_wc_d;
    logic [7:0]          hdr_ecc_q,   hdr_ecc_d;
    logic                len_err_q,   len_err_d;
    logic                abort_q,     abort_d;
    logic [15:0]         pkt_count_q, pkt_count_d;

    // -----------------------------------------------------------------------
    // Header assembly
    //
    // hdr_word is the full 4-byte header as it looks on the last header beat:
    // the current beat sits in the top bytes, and earlier beats sit below it.
    // With 4 lanes the whole header arrives in one beat. With fewer lanes, a
    // shift register holds the bytes from the preceding beats. Header beats
    // are always consecutive, because a gap aborts the packet, so the register
    // can shift every cycle without an enable.
    // -----------------------------------------------------------------------
    logic [31:0] hdr_word;

    generate
        if (LANES == 4) begin : g_hdr_direct
            assign hdr_word = lane_data;
        end else begin : g_hdr_shift
            localparam int unsigned PEND_W = 32 - 8 * LANES;
            logic [PEND_W-1:0] pend_q;

            assign hdr_word = {lane_data, pend_q};

            // NOTE: no reset here: every byte is overwritten by real header
            // beats before the last header beat reads it.
            always_ff @(posedge clk) begin
                pend_q <= hdr_word[31 -: PEND_W];
            end
        end
    endgenerate

    logic [7:0]  word_di;
    logic [15:0] word_wc;
    logic [7:0]  word_ecc;
    logic        word_short;
    logic [16:0] payload_beats;
    logic        sot_hit;

    assign word_di    = hdr_word[7:0];
    assign word_wc    = hdr_word[23:8];
    assign word_ecc   = hdr_word[31:24];
    assign word_short = (word_di[5:0] < 6'h10);

    // ceil((WC + CRC_BYTES) / LANES), computed without truncation.
    assign payload_beats = ({1'b0, word_wc} + CRC_EXT + ROUND_UP) / LANES_EXT;

    assign sot_hit = lane_valid && (lane_data == {LANES{SOT_BYTE}});

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        beat_cnt_d  = beat_cnt_q;
        out_gate_d  = 1'b0;
        hdr_valid_d = 1'b0;
        len_err_d   = 1'b0;
        abort_d     = 1'b0;
        hdr_di_d    = hdr_di_q;
        hdr_wc_d    = hdr_wc_q;
        hdr_ecc_d   = hdr_ecc_q;
        pkt_count_d = pkt_count_q;

        unique case (state_q)
            IDLE: begin
                if (sot_hit) begin
                    state_d    = HDR;
                    hdr_idx_d  = 2'd0;
                    out_gate_d = 1'b1;
                end
            end

            HDR: begin
                if (!lane_valid) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    out_gate_d = 1'b1;
                    if (hdr_idx_q == HDR_LAST) begin
                        hdr_valid_d = 1'b1;
                        hdr_di_d    = word_di;
                        hdr_wc_d    = word_wc;
                        hdr_ecc_d   = word_ecc;
                        if (word_short) begin
                            state_d     = IDLE;
                            pkt_count_d = pkt_count_q + 16'd1;
                        end else if (word_wc > MAX_WC) begin
                            len_err_d = 1'b1;
                            state_d   = IDLE;
                        end else if (payload_beats == 17'd0) begin
                            // Only possible with no trailer and WC = 0.
                            state_d     = IDLE;
                            pkt_count_d = pkt_count_q + 16'd1;
                        end else begin
                            state_d    = PAYLOAD;
                            beat_cnt_d = payload_beats;
                        end
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end

            PAYLOAD: begin
                if (!lane_valid) begin
                    abort_d    = 1'b1;
                    state_d    = IDLE;
                    beat_cnt_d = 17'd0;
                end else begin
                    out_gate_d = 1'b1;
                    beat_cnt_d = beat_cnt_q - 17'd1;
                    if (beat_cnt_q == 17'd1) begin
                        state_d     = IDLE;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                beat_cnt_d = 17'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register updates from the
        // values it saw before the edge, whatever order the statements are in.
        if (reset) begin
            state_q     <= IDLE;
            hdr_idx_q   <= 2'd0;
            beat_cnt_q  <= 17'd0;
            out_data_q  <= '0;
            out_gate_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_di_q    <= 8'd0;
            hdr_wc_q    <= 16'd0;
            hdr_ecc_q   <= 8'd0;
            len_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            out_data_q  <= lane_data;
            out_gate_q  <= out_gate_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_di_q    <= hdr_di_d;
            hdr_wc_q    <= hdr_wc_d;
            hdr_ecc_q   <= hdr_ecc_d;
            len_err_q   <= len_err_d;
            abort_q     <= abort_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_gate  = out_gate_q;
    assign hdr_valid = hdr_valid_q;
    assign hdr_di    = hdr_di_q;
    assign hdr_wc    = hdr_wc_q;
    assign hdr_ecc   = hdr_ecc_q;
    assign len_err   = len_err_q;
    assign abort     = abort_q;
    assign pkt_count = pkt_count_q;

endmodule
